// File: rtl/cnn_axis_pkg.sv
// Shared definitions for the CNN result stream path: FIFO word widths,
// transmitter state encoding and result-word extension.
package cnn_axis_pkg;

    localparam int unsigned FIFO_OUT_DATA_IN_WH  = 20;
    localparam int unsigned FIFO_OUT_DATA_OUT_WH = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } tx_state_e;

    // Widen a convolution result to the stream width, zero- or sign-filled.
    function automatic logic [FIFO_OUT_DATA_OUT_WH-1:0] extend_result(
        input logic [FIFO_OUT_DATA_IN_WH-1:0] res,
        input logic                           sign_ext
    );
        logic fill;
        fill = sign_ext & res[FIFO_OUT_DATA_IN_WH-1];
        return {{(FIFO_OUT_DATA_OUT_WH - FIFO_OUT_DATA_IN_WH){fill}}, res};
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI-Stream output register: a load overwrites the entry, an
// accept without a load empties it.
module axis_out_reg
    import cnn_axis_pkg::*;
#(
    parameter int unsigned W = FIFO_OUT_DATA_OUT_WH
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         accept_i,
    input  logic [W-1:0] data_i,
    input  logic         last_i,
    output logic [W-1:0] tdata_o,
    output logic         tvalid_o,
    output logic         tlast_o
);

    logic [W-1:0] tdata_q;
    logic         tvalid_q;
    logic         tlast_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else if (load_i) begin
            tdata_q  <= data_i;
            tvalid_q <= 1'b1;
            tlast_q  <= last_i;
        end else if (tvalid_q && accept_i) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end
    end

    assign tdata_o  = tdata_q;
    assign tvalid_o = tvalid_q;
    assign tlast_o  = tlast_q;

endmodule

// File: rtl/conv_result_axis_tx.sv
// Drains convolution results from the FWFT result FIFO and sends one
// output feature map per start as an AXI4-Stream frame with TLAST.
module conv_result_axis_tx
    import cnn_axis_pkg::*;
#(
    parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_RESULT_WIDTH       = 20,
    parameter int unsigned C_SIGN_EXTEND        = 0,
    parameter int unsigned C_CNT_WIDTH          = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [C_CNT_WIDTH-1:0]            frame_len,
    output logic                              busy,
    output logic                              done,
    input  logic                              fifo_empty,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   fifo_data,
    output logic                              fifo_read,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep
);

    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

    tx_state_e                 state_q;
    logic [C_CNT_WIDTH-1:0]    len_q;
    logic [C_CNT_WIDTH-1:0]    beat_cnt_q;
    logic                      busy_q;
    logic                      done_q;

    logic                      load;
    logic                      last_beat;
    logic                      final_hs;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] ext_data;
    logic                      unused_fifo_hi;

    // Upper FIFO word bits carry no result information.
    assign unused_fifo_hi = ^fifo_data[C_M_AXIS_TDATA_WIDTH-1:C_RESULT_WIDTH];

    assign ext_data  = extend_result(fifo_data[C_RESULT_WIDTH-1:0], C_SIGN_EXTEND != 0);
    assign load      = (state_q == STREAM) && !fifo_empty && (beat_cnt_q < len_q)
                       && (!m_axis_tvalid || m_axis_tready);
    assign last_beat = (beat_cnt_q == len_q - CNT_ONE);
    assign final_hs  = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && (frame_len != '0)) begin
                        len_q      <= frame_len;
                        beat_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= STREAM;
                    end
                end
                STREAM: begin
                    if (load) begin
                        beat_cnt_q <= beat_cnt_q + CNT_ONE;
                    end
                    if (final_hs) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    axis_out_reg #(
        .W(C_M_AXIS_TDATA_WIDTH)
    ) u_out_reg (
        .clk_i    (clk),
        .rst_i    (reset),
        .load_i   (load),
        .accept_i (m_axis_tready),
        .data_i   (ext_data),
        .last_i   (last_beat),
        .tdata_o  (m_axis_tdata),
        .tvalid_o (m_axis_tvalid),
        .tlast_o  (m_axis_tlast)
    );

    assign fifo_read    = load;
    assign busy         = busy_q;
    assign done         = done_q;
    assign m_axis_tkeep = '1;

endmodule

// File: tb/tb_conv_result_axis_tx.sv
// Directed bench for conv_result_axis_tx: a queue models the FWFT FIFO, a
// monitor logs handshaked beats; a sign-extending twin checks extension.
module tb_conv_result_axis_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] frame_len = '0;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_data = '0;
    logic        tready = 1'b1;

    logic        busy0, done0, fifo_read0, tvalid0, tlast0;
    logic [31:0] tdata0;
    logic [3:0]  tkeep0;
    logic        busy1, done1, fifo_read1, tvalid1, tlast1;
    logic [31:0] tdata1;
    logic [3:0]  tkeep1;

    always #5 clk = ~clk;

    conv_result_axis_tx #(.C_SIGN_EXTEND(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
        .busy(busy0), .done(done0), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_read(fifo_read0), .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0),
        .m_axis_tready(tready), .m_axis_tlast(tlast0), .m_axis_tkeep(tkeep0)
    );

    conv_result_axis_tx #(.C_SIGN_EXTEND(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
        .busy(busy1), .done(done1), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_read(fifo_read1), .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1),
        .m_axis_tready(tready), .m_axis_tlast(tlast1), .m_axis_tkeep(tkeep1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    logic [31:0] fq[$];
    logic [31:0] log_d0[$];
    logic [31:0] log_d1[$];
    logic        log_last[$];
    int reads = 0, dones = 0, cyc = 0, ctrl_diff = 0;
    int start_cyc = -1, first_hs = -1, last_hs = -1, done_cyc = -1;

    // Monitor and FIFO model: sample pre-edge values, pop on fifo_read.
    always @(posedge clk) begin
        if (tvalid0 && tready) begin
            log_d0.push_back(tdata0);
            log_d1.push_back(tdata1);
            log_last.push_back(tlast0);
            if (first_hs < 0) first_hs = cyc;
            if (tlast0) last_hs = cyc;
        end
        if (done0) begin
            dones++;
            done_cyc = cyc;
        end
        if (start && !busy0 && frame_len != 16'd0 && !reset) start_cyc = cyc;
        if ({fifo_read1, busy1, done1, tvalid1, tlast1, tkeep1}
            != {fifo_read0, busy0, done0, tvalid0, tlast0, tkeep0}) ctrl_diff++;
        if (fifo_read0) begin
            reads++;
            if (fq.size() != 0) void'(fq.pop_front());
        end
        fifo_empty <= (fq.size() == 0);
        fifo_data  <= (fq.size() != 0) ? fq[0] : 32'd0;
        cyc++;
    end

    task automatic push(input logic [31:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
        fifo_data  = fq[0];
    endtask

    task automatic clear_log();
        log_d0.delete();
        log_d1.delete();
        log_last.delete();
        reads = 0; dones = 0;
        start_cyc = -1; first_hs = -1; last_hs = -1; done_cyc = -1;
    endtask

    task automatic start_frame(input logic [15:0] len);
        @(negedge clk);
        frame_len = len;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (dones == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_seen"}, 32'(dones != 0), 32'd1);
        repeat (3) @(negedge clk);
        chk({tag, "_done_once"}, dones, 1);
        chk({tag, "_done_lat"}, done_cyc - last_hs, 1);
    endtask

    task automatic check_seq(input string tag, input int n, input logic [31:0] first);
        chk({tag, "_beats"}, log_d0.size(), n);
        chk({tag, "_reads"}, reads, n);
        for (int i = 0; i < n && i < log_d0.size(); i++) begin
            chk($sformatf("%s_d%0d", tag, i), log_d0[i], first + 32'(i));
            chk($sformatf("%s_l%0d", tag, i), 32'(log_last[i]), 32'(i == n - 1));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] bp_tab [5];
        int k;
        bp_tab = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1};

        repeat (3) @(negedge clk);
        chk("rst_tvalid", 32'(tvalid0), 0);
        chk("rst_tlast", 32'(tlast0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_tdata", tdata0, 32'h0);
        chk("rst_fifo_read", 32'(fifo_read0), 0);
        chk("rst_tkeep", 32'(tkeep0), 32'hF);
        reset = 1'b0;
        clear_log();

        // Basic frame of 4 with the FIFO preloaded.
        for (int i = 1; i <= 4; i++) push(32'(i));
        start_frame(16'd4);
        wait_done("t1", 20);
        check_seq("t1", 4, 32'h1);
        chk("t1_first_lat", first_hs - start_cyc, 2);
        chk("t1_span", last_hs - first_hs, 3);

        // Backpressure with tready 1,0,0,1,1.
        clear_log();
        for (int i = 0; i < 3; i++) push(32'h10 + 32'(i));
        start_frame(16'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tready = bp_tab[i][0];
            #1;
            if (!tready) begin
                chk($sformatf("t2_hold_v%0d", i), 32'(tvalid0), 1);
                chk($sformatf("t2_hold_d%0d", i), tdata0, 32'h11);
                chk($sformatf("t2_hold_l%0d", i), 32'(tlast0), 0);
                chk($sformatf("t2_hold_rd%0d", i), 32'(fifo_read0), 0);
            end
        end
        tready = 1'b1;
        wait_done("t2", 20);
        check_seq("t2", 3, 32'h10);

        // Underflow: 2 words, then 3 more after a gap.
        clear_log();
        push(32'h20);
        push(32'h21);
        start_frame(16'd5);
        repeat (10) @(negedge clk);
        chk("t3_gap_tvalid", 32'(tvalid0), 0);
        chk("t3_gap_busy", 32'(busy0), 1);
        chk("t3_gap_beats", log_d0.size(), 2);
        chk("t3_gap_done", dones, 0);
        for (int i = 2; i < 5; i++) push(32'h20 + 32'(i));
        wait_done("t3", 20);
        check_seq("t3", 5, 32'h20);

        // Frame boundary: 6 words, frames of 4 then 2.
        clear_log();
        for (int i = 1; i <= 6; i++) push(32'h30 + 32'(i));
        start_frame(16'd4);
        wait_done("t4a", 20);
        check_seq("t4a", 4, 32'h31);
        chk("t4a_left", fq.size(), 2);
        clear_log();
        start_frame(16'd2);
        wait_done("t4b", 20);
        check_seq("t4b", 2, 32'h35);
        chk("t4b_left", fq.size(), 0);

        // Extension, with junk in the ignored upper bits.
        clear_log();
        push(32'hABC8_0000);
        start_frame(16'd1);
        wait_done("t5", 20);
        chk("t5_beats", log_d0.size(), 1);
        if (log_d0.size() != 0) begin
            chk("t5_zext", log_d0[0], 32'h0008_0000);
            chk("t5_sext", log_d1[0], 32'hFFF8_0000);
            chk("t5_tlast", 32'(log_last[0]), 1);
        end

        // Zero-length start is ignored.
        clear_log();
        push(32'h55);
        start_frame(16'd0);
        chk("t5z_busy", 32'(busy0), 0);
        repeat (5) @(negedge clk);
        chk("t5z_busy_late", 32'(busy0), 0);
        chk("t5z_done", dones, 0);
        chk("t5z_reads", reads, 0);
        chk("t5z_tvalid", 32'(tvalid0), 0);
        void'(fq.pop_front());
        fifo_empty = (fq.size() == 0);

        // Reset after 2 of 5 beats, then a fresh frame of 3.
        clear_log();
        for (int i = 1; i <= 8; i++) push(32'h40 + 32'(i));
        start_frame(16'd5);
        k = 0;
        while (log_d0.size() < 2 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t6_pre_beats", log_d0.size(), 2);
        tready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_tvalid", 32'(tvalid0), 0);
        chk("t6_rst_busy", 32'(busy0), 0);
        chk("t6_rst_tlast", 32'(tlast0), 0);
        chk("t6_rst_tdata", tdata0, 32'h0);
        chk("t6_rst_beats", log_d0.size(), 2);
        chk("t6_rst_reads", reads, 3);
        reset = 1'b0;
        tready = 1'b1;
        clear_log();
        start_frame(16'd3);
        wait_done("t6", 20);
        check_seq("t6", 3, 32'h44);
        chk("t6_left", fq.size(), 2);

        chk("twin_ctrl_diff", ctrl_diff, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
